// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, byte type, FSM states and the
// InvShiftRows source-index helper used by byte-serial stages.
package aes_pkg;

    localparam int AES_BYTES = 16;
    localparam int STATE_W   = 128;

    typedef logic [7:0] byte_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    // Byte k = row (k & 3), column (k >> 2). Row r of the inverse shift
    // rotates right by r, so output column c reads input column (c - r) mod 4.
    // The 2-bit subtraction wraps modulo 4 on its own.
    function automatic logic [3:0] inv_shift_src(input logic [3:0] k);
        logic [1:0] row;
        logic [1:0] col;
        row = k[1:0];
        col = k[3:2] - k[1:0];
        return {col, row};
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// FIPS-197 inverse S-box: purely combinational 256-entry byte lookup.
module inv_sbox
    import aes_pkg::*;
(
    input  byte_t byte_i,
    output byte_t byte_o
);

    // Entry n sits at bits [8n +: 8]; entry 0 is the leftmost byte.
    localparam logic [0:2047] INV_SBOX_ROM = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign byte_o = INV_SBOX_ROM[{byte_i, 3'b000} +: 8];

endmodule

// File: rtl/inv_shift_sub_bytes.sv
// Byte-serial InvShiftRows + InvSubBytes: captures a 128-bit state on start,
// pushes one byte per clock through a shared inverse S-box and publishes the
// complete result with a one-cycle done pulse after 16 clocks.
module inv_shift_sub_bytes
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [0:STATE_W-1] state_in,
    output logic [0:STATE_W-1] state_out,
    output logic               busy,
    output logic               done
);

    localparam logic [3:0] LAST_K = 4'(AES_BYTES - 1);

    state_e             state_q;
    logic [3:0]         k_q;
    logic [0:STATE_W-1] work_q;
    // Bytes 0..14 accumulate here in order; byte 15 comes straight from the
    // S-box in the final cycle, so the shadow never holds it.
    logic [0:STATE_W-9] shadow_q;
    logic [0:STATE_W-1] state_out_q;
    logic               busy_q;
    logic               done_q;

    logic [3:0]         src;
    byte_t              sbox_in;
    byte_t              sbox_out;
    logic [0:STATE_W-1] result_d;

    // Select the source byte for the current output position and assemble
    // the full result for the completion cycle.
    always_comb begin
        src      = inv_shift_src(k_q);
        sbox_in  = work_q[{src, 3'b000} +: 8];
        result_d = {shadow_q, sbox_out};
    end

    inv_sbox u_inv_sbox (
        .byte_i (sbox_in),
        .byte_o (sbox_out)
    );

    // FSM, byte counter, work/shadow registers and registered outputs.
    // NOTE: every register here is updated with <= so all of them see the
    // pre-edge values of each other; mixing in = would make the shadow shift
    // and the counter increment order-dependent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: work and shadow are reset too, so a run aborted by reset
            // cannot leak bytes from the old block into a later result.
            state_q     <= IDLE;
            k_q         <= 4'd0;
            work_q      <= '0;
            shadow_q    <= '0;
            state_out_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        work_q  <= state_in;
                        k_q     <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    shadow_q <= {shadow_q[8:STATE_W-9], sbox_out};
                    k_q      <= k_q + 4'd1;
                    if (k_q == LAST_K) begin
                        state_out_q <= result_d;
                        done_q      <= 1'b1;
                        // A start seen on the completion edge begins the next
                        // block immediately (k wraps to 0), giving one block
                        // every 16 clocks; otherwise fall back to idle.
                        if (start) begin
                            work_q <= state_in;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign state_out = state_out_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_inv_shift_sub_bytes.sv
// Self-checking bench for inv_shift_sub_bytes: table-driven vectors through a
// scoreboard, plus back-to-back, reset-mid-run and idle-stability sequences.
module tb_inv_shift_sub_bytes;

    logic         clk;
    logic         rst;
    logic         start;
    logic [0:127] state_in;
    logic [0:127] state_out;
    logic         busy;
    logic         done;

    inv_shift_sub_bytes dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .state_in  (state_in),
        .state_out (state_out),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [0:127] exp;
        int           start_cyc;
    } sb_t;

    typedef struct {
        string        name;
        logic [0:127] din;
        logic [0:127] exp;
    } vec_t;

    sb_t  sb[$];
    int   done_cycles[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    logic [7:0] inv_tab [256];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Build the inverse S-box by inverting the forward S-box derived from
    // the GF(2^8) multiplicative inverse followed by the affine transform.
    task automatic build_inv_tab();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [0:127] inv_shift(input logic [0:127] s);
        logic [0:127] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[8*(4*c + r) +: 8] = s[8*(4*((c - r + 4) % 4) + r) +: 8];
        return o;
    endfunction

    function automatic logic [0:127] model(input logic [0:127] s);
        logic [0:127] t;
        t = inv_shift(s);
        for (int k = 0; k < 16; k++) t[8*k +: 8] = inv_tab[t[8*k +: 8]];
        return t;
    endfunction

    // ---------------- scoreboard monitor ----------------
    initial begin
        sb_t e;
        forever begin
            @(posedge clk);
            #2;
            if (done === 1'b1) begin
                done_cycles.push_back(cyc);
                if (sb.size() == 0) begin
                    check("done_without_start", 128'(sb.size()), 128'd1);
                end else begin
                    e = sb.pop_front();
                    check("result", state_out, e.exp);
                    check("latency", 128'(cyc - e.start_cyc), 128'd16);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check("drain", 128'(sb.size()), 128'd0);
    endtask

    function automatic logic [0:127] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_vector(input string name, input logic [0:127] din, input logic [0:127] exp);
        state_in = din;
        start    = 1'b1;
        tick();
        sb.push_back('{exp, cyc});
        start    = 1'b0;
        state_in = rand128();
        check({name, " busy_in_run"}, 128'(busy), 128'd1);
        wait_drain();
        check({name, " busy_after"}, 128'(busy), 128'd0);
        check({name, " done_after"}, 128'(done), 128'd0);
    endtask

    // ---------------- main test ----------------
    localparam logic [0:127] FIPS_IN  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [0:127] FIPS_SH  = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
    localparam logic [0:127] FIPS_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    localparam logic [0:127] SEQ_IN   = 128'h000102030405060708090a0b0c0d0e0f;

    vec_t vecs[6];

    initial begin
        logic [0:127] a;
        logic [0:127] b;
        logic [0:127] v;
        logic [0:127] last;
        logic         saw_busy;
        logic         saw_done;

        rst      = 1'b1;
        start    = 1'b0;
        state_in = '0;
        build_inv_tab();

        vecs[0] = '{"fips_round1", FIPS_IN,       FIPS_OUT};
        vecs[1] = '{"all_zero",    '0,            {16{8'h52}}};
        vecs[2] = '{"all_63",      {16{8'h63}},   '0};
        vecs[3] = '{"ramp",        SEQ_IN,        model(SEQ_IN)};
        a = rand128();
        b = rand128();
        vecs[4] = '{"random_a",    a,             model(a)};
        vecs[5] = '{"random_b",    b,             model(b)};

        check("model_shift_fips", inv_shift(FIPS_IN), FIPS_SH);
        check("ramp_byte1", 128'(vecs[3].exp[8:15]), 128'h f3);

        // power-up reset
        tick();
        tick();
        check("reset state_out", state_out, '0);
        check("reset busy", 128'(busy), 128'd0);
        check("reset done", 128'(done), 128'd0);
        rst = 1'b0;
        tick();
        check("post_reset busy", 128'(busy), 128'd0);

        // table-driven vectors
        for (int i = 0; i < 6; i++) run_vector(vecs[i].name, vecs[i].din, vecs[i].exp);

        // back-to-back with start held high; state_in changes mid-run
        a = rand128();
        b = rand128();
        done_cycles.delete();
        state_in = a;
        start    = 1'b1;
        tick();                              // E0: a captured
        sb.push_back('{model(a), cyc});
        state_in = b;                        // ignored until completion edge
        repeat (15) tick();                  // E15
        tick();                              // E16: b captured
        sb.push_back('{model(b), cyc});
        check("b2b busy_kept", 128'(busy), 128'd1);
        state_in = rand128();
        tick();
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("b2b state_out_held", state_out, model(a));
        wait_drain();
        check("b2b done_count", 128'(done_cycles.size()), 128'd2);
        if (done_cycles.size() == 2)
            check("b2b done_spacing", 128'(done_cycles[1] - done_cycles[0]), 128'd16);

        // asynchronous reset during run cycle 7
        state_in = rand128();
        start    = 1'b1;
        tick();
        sb.push_back('{model(state_in), cyc});
        start = 1'b0;
        repeat (7) tick();
        #2;
        rst = 1'b1;
        #1;
        check("midrst state_out", state_out, '0);
        check("midrst busy", 128'(busy), 128'd0);
        check("midrst done", 128'(done), 128'd0);
        sb.delete();
        tick();
        rst = 1'b0;
        tick();
        check("midrst held busy", 128'(busy), 128'd0);
        v = rand128();
        state_in = v;
        start    = 1'b1;
        tick();
        sb.push_back('{model(v), cyc});
        start    = 1'b0;
        state_in = rand128();
        repeat (8) tick();
        check("midrst no_partial", state_out, '0);
        wait_drain();

        // idle stability
        last     = state_out;
        saw_busy = 1'b0;
        saw_done = 1'b0;
        repeat (100) begin
            tick();
            if (busy !== 1'b0) saw_busy = 1'b1;
            if (done !== 1'b0) saw_done = 1'b1;
        end
        check("idle busy", 128'(saw_busy), 128'd0);
        check("idle done", 128'(saw_done), 128'd0);
        check("idle state_out", state_out, last);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
